// File: rtl/led_bar_monitor.sv
// LED bar flasher monitor: samples a thermometer-coded LED bar, tracks its level
// and direction, flags reversals, counts full-bar blinks and latches the first fault.
module led_bar_monitor #(
  parameter int N = 16,
  localparam int LW = $clog2(N + 1),
  localparam int DW = LW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  LED,
  output logic [LW-1:0] level,
  output logic [2:0]    state,
  output logic          bound_vld,
  output logic          bound_peak,
  output logic [LW-1:0] bound_lvl,
  output logic [3:0]    blink_cnt,
  output logic          err,
  output logic [1:0]    err_code
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RISE  = 3'd1,
    ST_FALL  = 3'd2,
    ST_BLINK = 3'd3,
    ST_FAULT = 3'd4
  } mon_state_e;

  logic [N-1:0]   sample_r;
  logic           smp_vld_r;
  logic           base_r;
  mon_state_e     state_r;

  logic           legal_s;
  logic [LW-1:0]  k_s;
  logic signed [DW-1:0] delta_s;
  logic           blink_s;

  mon_state_e     state_n;
  logic [LW-1:0]  level_n;
  logic           bvld_n;
  logic           bpeak_n;
  logic [LW-1:0]  blvl_n;
  logic [3:0]     bcnt_n;
  logic           err_n;
  logic [1:0]     code_n;
  logic           base_n;

  assign state = state_r;

  // Stage 1: capture the raw LED bar; smp_vld_r keeps the reset value out of the baseline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_r  <= {N{1'b0}};
      smp_vld_r <= 1'b0;
    end else begin
      sample_r  <= LED;
      smp_vld_r <= 1'b1;
    end
  end

  // Decode stage-1 sample: thermometer legality, lit count and signed step.
  always_comb begin
    k_s = {LW{1'b0}};
    for (int i = 0; i < N; i++) begin
      k_s = k_s + LW'(sample_r[i]);
    end
    legal_s = ((sample_r & (sample_r + {{(N-1){1'b0}}, 1'b1})) == {N{1'b0}});
    delta_s = $signed({1'b0, k_s}) - $signed({1'b0, level});
    blink_s = ((level == {LW{1'b0}}) && (k_s == LW'(N))) ||
              ((level == LW'(N)) && (k_s == {LW{1'b0}}));
  end

  // Stage 2 next-state and output decision.
  always_comb begin
    state_n = state_r;
    level_n = level;
    bvld_n  = 1'b0;
    bpeak_n = bound_peak;
    blvl_n  = bound_lvl;
    bcnt_n  = blink_cnt;
    err_n   = err;
    code_n  = err_code;
    base_n  = base_r;
    if (!smp_vld_r) begin
      state_n = state_r;
    end else if (state_r == ST_FAULT) begin
      // Only an empty bar clears the fault state; the error flag itself stays sticky.
      if (legal_s && (k_s == {LW{1'b0}})) begin
        state_n = ST_IDLE;
        level_n = {LW{1'b0}};
        base_n  = 1'b1;
      end else begin
        state_n = ST_FAULT;
      end
    end else if (!legal_s) begin
      state_n = ST_FAULT;
      err_n   = 1'b1;
      if (err_code == 2'b00) begin
        code_n = 2'b01;
      end else begin
        code_n = err_code;
      end
    end else if (!base_r) begin
      base_n  = 1'b1;
      level_n = k_s;
      state_n = (k_s == {LW{1'b0}}) ? ST_IDLE : ST_RISE;
    end else if (blink_s) begin
      state_n = ST_BLINK;
      level_n = k_s;
      if (state_r != ST_BLINK) begin
        bcnt_n = 4'd1;
      end else if (blink_cnt != 4'd15) begin
        bcnt_n = blink_cnt + 4'd1;
      end else begin
        bcnt_n = blink_cnt;
      end
    end else if (delta_s == DW'(1)) begin
      state_n = ST_RISE;
      level_n = k_s;
      if (state_r == ST_FALL) begin
        bvld_n  = 1'b1;
        bpeak_n = 1'b0;
        blvl_n  = level;
      end else begin
        bvld_n  = 1'b0;
      end
    end else if (delta_s == DW'(-1)) begin
      state_n = ST_FALL;
      level_n = k_s;
      if (state_r == ST_RISE) begin
        bvld_n  = 1'b1;
        bpeak_n = 1'b1;
        blvl_n  = level;
      end else begin
        bvld_n  = 1'b0;
      end
    end else if (delta_s == DW'(0)) begin
      if (k_s == {LW{1'b0}}) begin
        state_n = ST_IDLE;
      end else begin
        state_n = state_r;
      end
    end else begin
      state_n = ST_FAULT;
      level_n = k_s;
      err_n   = 1'b1;
      if (err_code == 2'b00) begin
        code_n = 2'b10;
      end else begin
        code_n = err_code;
      end
    end
  end

  // Stage 2 registers: every output is driven straight from a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      level      <= {LW{1'b0}};
      bound_vld  <= 1'b0;
      bound_peak <= 1'b0;
      bound_lvl  <= {LW{1'b0}};
      blink_cnt  <= 4'd0;
      err        <= 1'b0;
      err_code   <= 2'b00;
      base_r     <= 1'b0;
    end else begin
      state_r    <= state_n;
      level      <= level_n;
      bound_vld  <= bvld_n;
      bound_peak <= bpeak_n;
      bound_lvl  <= blvl_n;
      blink_cnt  <= bcnt_n;
      err        <= err_n;
      err_code   <= code_n;
      base_r     <= base_n;
    end
  end

endmodule

// File: tb/tb_led_bar_monitor.sv
// Directed self-checking bench for led_bar_monitor; one LED vector per clock,
// outputs observed one step later reflect the previous vector.
module tb_led_bar_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] LED = 16'h0000;
  logic [4:0]  level;
  logic [2:0]  state;
  logic        bound_vld;
  logic        bound_peak;
  logic [4:0]  bound_lvl;
  logic [3:0]  blink_cnt;
  logic        err;
  logic [1:0]  err_code;

  int errors = 0;
  int checks = 0;

  led_bar_monitor #(.N(16)) dut (
    .clk(clk), .reset(reset), .LED(LED), .level(level), .state(state),
    .bound_vld(bound_vld), .bound_peak(bound_peak), .bound_lvl(bound_lvl),
    .blink_cnt(blink_cnt), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  wire [21:0] obs = {state, level, bound_vld, bound_peak, bound_lvl, blink_cnt, err, err_code};

  function automatic logic [21:0] ex(input logic [2:0] st, input logic [4:0] lv,
                                     input logic bv, input logic bp, input logic [4:0] bl,
                                     input logic [3:0] bc, input logic e, input logic [1:0] ec);
    return {st, lv, bv, bp, bl, bc, e, ec};
  endfunction

  task automatic step(input logic [15:0] v);
    LED = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    LED = 16'h0000;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    LED = 16'h0000;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (obs !== ex(3'd0, 5'd0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 2'b00)) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", obs, ex(3'd0, 5'd0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 2'b00));
    end
    reset = 1'b1;
  endtask

  task automatic test_rise_fall();
    logic [15:0] v [20];
    logic [21:0] e [20];
    do_reset();
    v = '{16'h0000, 16'h0001, 16'h0003, 16'h0007, 16'h000F, 16'h001F, 16'h003F, 16'h001F,
          16'h000F, 16'h0007, 16'h0003, 16'h0001, 16'h0000, 16'h0001, 16'h0000, 16'h0000,
          16'h0000, 16'h0001, 16'h0001, 16'h0003};
    e = '{ex(3'd0, 5'd0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 2'b00), ex(3'd0, 5'd0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 2'b00),
          ex(3'd1, 5'd1, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 2'b00), ex(3'd1, 5'd2, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 2'b00),
          ex(3'd1, 5'd3, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 2'b00), ex(3'd1, 5'd4, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 2'b00),
          ex(3'd1, 5'd5, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 2'b00), ex(3'd1, 5'd6, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 2'b00),
          ex(3'd2, 5'd5, 1'b1, 1'b1, 5'd6, 4'd0, 1'b0, 2'b00), ex(3'd2, 5'd4, 1'b0, 1'b1, 5'd6, 4'd0, 1'b0, 2'b00),
          ex(3'd2, 5'd3, 1'b0, 1'b1, 5'd6, 4'd0, 1'b0, 2'b00), ex(3'd2, 5'd2, 1'b0, 1'b1, 5'd6, 4'd0, 1'b0, 2'b00),
          ex(3'd2, 5'd1, 1'b0, 1'b1, 5'd6, 4'd0, 1'b0, 2'b00), ex(3'd2, 5'd0, 1'b0, 1'b1, 5'd6, 4'd0, 1'b0, 2'b00),
          ex(3'd1, 5'd1, 1'b1, 1'b0, 5'd0, 4'd0, 1'b0, 2'b00), ex(3'd2, 5'd0, 1'b1, 1'b1, 5'd1, 4'd0, 1'b0, 2'b00),
          ex(3'd0, 5'd0, 1'b0, 1'b1, 5'd1, 4'd0, 1'b0, 2'b00), ex(3'd0, 5'd0, 1'b0, 1'b1, 5'd1, 4'd0, 1'b0, 2'b00),
          ex(3'd1, 5'd1, 1'b0, 1'b1, 5'd1, 4'd0, 1'b0, 2'b00), ex(3'd1, 5'd1, 1'b0, 1'b1, 5'd1, 4'd0, 1'b0, 2'b00)};
    for (int i = 0; i < 20; i++) begin
      step(v[i]);
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL rise_fall[%0d]: got %h want %h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_blink();
    logic [15:0] t;
    logic [15:0] r;
    logic [21:0] want;
    int j;
    do_reset();
    for (int k = 0; k <= 16; k++) begin
      r = 16'((32'd1 << k) - 32'd1);
      step(r);
    end
    for (int i = 0; i < 20; i++) begin
      t = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
      step(t);
      j = i - 1;
      if (j < 1) begin
        want = ex(3'd1, 5'd16, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 2'b00);
      end else begin
        want = ex(3'd3, (j % 2 == 0) ? 5'd16 : 5'd0, 1'b0, 1'b0, 5'd0,
                  (j > 15) ? 4'd15 : 4'(j), 1'b0, 2'b00);
      end
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL blink[%0d]: got %h want %h", i, obs, want);
      end
    end
    step(16'h0000);
    checks++;
    if (obs !== ex(3'd3, 5'd0, 1'b0, 1'b0, 5'd0, 4'd15, 1'b0, 2'b00)) begin
      errors++;
      $display("FAIL blink_sat: got %h want %h", obs, ex(3'd3, 5'd0, 1'b0, 1'b0, 5'd0, 4'd15, 1'b0, 2'b00));
    end
    step(16'h0000);
    checks++;
    if (obs !== ex(3'd0, 5'd0, 1'b0, 1'b0, 5'd0, 4'd15, 1'b0, 2'b00)) begin
      errors++;
      $display("FAIL blink_exit_hold: got %h want %h", obs, ex(3'd0, 5'd0, 1'b0, 1'b0, 5'd0, 4'd15, 1'b0, 2'b00));
    end
    step(16'hFFFF);
    step(16'hFFFF);
    checks++;
    if (obs !== ex(3'd3, 5'd16, 1'b0, 1'b0, 5'd0, 4'd1, 1'b0, 2'b00)) begin
      errors++;
      $display("FAIL blink_reload: got %h want %h", obs, ex(3'd3, 5'd16, 1'b0, 1'b0, 5'd0, 4'd1, 1'b0, 2'b00));
    end
  endtask

  task automatic test_fault();
    logic [15:0] v [9];
    logic [21:0] e [9];
    logic [15:0] w [6];
    logic [21:0] f [6];
    do_reset();
    v = '{16'h0000, 16'h0001, 16'h0003, 16'h0005, 16'h00FF, 16'h0000, 16'h0000, 16'h0001, 16'h0003};
    e = '{ex(3'd0, 5'd0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 2'b00), ex(3'd0, 5'd0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 2'b00),
          ex(3'd1, 5'd1, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 2'b00), ex(3'd1, 5'd2, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 2'b00),
          ex(3'd4, 5'd2, 1'b0, 1'b0, 5'd0, 4'd0, 1'b1, 2'b01), ex(3'd4, 5'd2, 1'b0, 1'b0, 5'd0, 4'd0, 1'b1, 2'b01),
          ex(3'd0, 5'd0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b1, 2'b01), ex(3'd0, 5'd0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b1, 2'b01),
          ex(3'd1, 5'd1, 1'b0, 1'b0, 5'd0, 4'd0, 1'b1, 2'b01)};
    for (int i = 0; i < 9; i++) begin
      step(v[i]);
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL fault_pattern[%0d]: got %h want %h", i, obs, e[i]);
      end
    end
    do_reset();
    w = '{16'h0000, 16'h0001, 16'h000F, 16'h0000, 16'h0005, 16'h0000};
    f = '{ex(3'd0, 5'd0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 2'b00), ex(3'd0, 5'd0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 2'b00),
          ex(3'd1, 5'd1, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 2'b00), ex(3'd4, 5'd4, 1'b0, 1'b0, 5'd0, 4'd0, 1'b1, 2'b10),
          ex(3'd0, 5'd0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b1, 2'b10), ex(3'd4, 5'd0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b1, 2'b10)};
    for (int i = 0; i < 6; i++) begin
      step(w[i]);
      checks++;
      if (obs !== f[i]) begin
        errors++;
        $display("FAIL fault_step[%0d]: got %h want %h", i, obs, f[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    LED = 16'h03FF;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== ex(3'd0, 5'd0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 2'b00)) begin
      errors++;
      $display("FAIL mid_reset_async: got %h want %h", obs, ex(3'd0, 5'd0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 2'b00));
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs !== ex(3'd0, 5'd0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 2'b00)) begin
      errors++;
      $display("FAIL mid_reset_held: got %h want %h", obs, ex(3'd0, 5'd0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 2'b00));
    end
    reset = 1'b1;
    step(16'h03FF);
    checks++;
    if (obs !== ex(3'd0, 5'd0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 2'b00)) begin
      errors++;
      $display("FAIL release_first: got %h want %h", obs, ex(3'd0, 5'd0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 2'b00));
    end
    step(16'h03FF);
    checks++;
    if (obs !== ex(3'd1, 5'd10, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 2'b00)) begin
      errors++;
      $display("FAIL rebaseline: got %h want %h", obs, ex(3'd1, 5'd10, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 2'b00));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_rise_fall();
    test_blink();
    test_fault();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_bar_monitor.md
LED_BAR_MONITOR -- requirements
Module: led_bar_monitor

Interface
REQ-001 The module SHALL have parameter N, default 16, the number of LED lines observed; widths below are stated for N=16.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The module SHALL have port LED, input, 16, the LED bar driven by the flasher; bit 0 is the first LED to light.
REQ-005 The module SHALL have port level, output, 5, the number of lit LEDs (0..16) in the last legal sample.
REQ-006 The module SHALL have port state, output, 3, monitor state: IDLE=0, RISE=1, FALL=2, BLINK=3, FAULT=4.
REQ-007 The module SHALL have port bound_vld, output, 1, one-cycle pulse marking a direction reversal.
REQ-008 The module SHALL have port bound_peak, output, 1, reversal type (1 = peak RISE->FALL, 0 = trough FALL->RISE), valid with bound_vld.
REQ-009 The module SHALL have port bound_lvl, output, 5, the level at which the reversal occurred, valid with bound_vld.
REQ-010 The module SHALL have port blink_cnt, output, 4, the count of 0<->16 toggles in the current BLINK episode, saturating at 15.
REQ-011 The module SHALL have port err, output, 1, a sticky fault flag.
REQ-012 The module SHALL have port err_code, output, 2, the first fault cause: 00 none, 01 non-thermometer pattern, 10 step larger than one LED.

Function
REQ-013 The module SHALL register LED into a sample stage (stage 1) and derive all outputs as registers from stage 1 (stage 2), so LED present at rising edge N is reflected on outputs after edge N+1.
REQ-014 A sample SHALL be legal only if LED equals (2^k)-1 for some k in 0..16; then new level = k.
REQ-015 The first legal sample after reset SHALL be the baseline: level = k, with no step check applied; state becomes IDLE if k=0, else RISE.
REQ-016 Legal sample, delta +1: state -> RISE; if the previous state was FALL, bound_vld=1, bound_peak=0, bound_lvl=previous level.
REQ-017 Legal sample, delta -1: state -> FALL; if the previous state was RISE, bound_vld=1, bound_peak=1, bound_lvl=previous level.
REQ-018 Legal sample, delta 0: if level=0, state -> IDLE; otherwise state holds; no pulse.
REQ-019 Legal sample with previous level 0 and new level 16, or previous 16 and new 0: state -> BLINK; blink_cnt loads 1 on entry from a non-BLINK state, otherwise increments, saturating at 15.
REQ-020 Legal sample with |delta|>1 that is not covered by REQ-019: state -> FAULT; err=1; err_code=10 if err_code is 00; level updates to the new value.
REQ-021 Illegal sample: state -> FAULT; err=1; err_code=01 if err_code is 00; level holds.
REQ-022 In FAULT, a legal sample with level 0 SHALL return state to IDLE and re-baseline; any other sample SHALL keep FAULT; err and err_code SHALL stay unchanged.
REQ-023 bound_vld SHALL be deasserted in every cycle not named in REQ-016/017; bound_peak/bound_lvl hold their last values.
REQ-024 blink_cnt SHALL hold its value when leaving BLINK and reload per REQ-019 on the next BLINK entry.
REQ-025 level SHALL never exceed N; arithmetic on delta SHALL use signed 6-bit width.

Reset
REQ-026 While reset=0, asynchronously: stage-1 sample=0, baseline flag cleared, level=0, state=IDLE, bound_vld=0, bound_peak=0, bound_lvl=0, blink_cnt=0, err=0, err_code=00.
REQ-027 Reset asserted mid-sequence SHALL discard history; the first legal sample after release re-baselines per REQ-015 with no fault for any jump.

Verification
REQ-028 LED steps 0x0000 -> 0x0001 ... 0x003F, then 0x001F -> state RISE; on the first down step bound_vld one cycle, bound_peak=1, bound_lvl=6, state FALL, level=5.
REQ-029 LED falls to 0x0000, then rises to 0x0001 -> bound_vld, bound_peak=0, bound_lvl=0; LED held at 0x0000 for 3 cycles first -> state IDLE.
REQ-030 LED toggles 0xFFFF/0x0000 for 20 samples, starting from 0xFFFF with previous level 16 -> state BLINK, blink_cnt counts 1..15 and saturates at 15.
REQ-031 LED 0x0005 -> err=1, err_code=01, state FAULT, level held; a later 0x00FF jump leaves err_code=01; 0x0000 -> state IDLE, err still 1.
REQ-032 Reset pulsed low with LED=0x03FF, released with LED=0x03FF -> all outputs at reset values during low; after release level=10, state RISE, err=0.
